alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 instr_valid  input  1  instruction offered.
REQ-004 instr_ready  output  1  block can accept an instruction.
REQ-005 instr_op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB.
REQ-006 instr_rs, instr_rt  input  3 each  source register indices.
REQ-007 instr_rd  input  3  destination register index.
REQ-008 wr_en, wr_addr[2:0], wr_data[4:0]  input  preload write port.
REQ-009 read_data_1, read_data_2  output  5 each  operands to ALU, registered.
REQ-010 ALUcontrol  output  4  ALU opcode, registered.
REQ-011 ALUresult  input  5  ALU result; ALU registers it one clock after sampling operands.
REQ-012 wb_valid  output  1  one-cycle pulse on register writeback; wb_rd[2:0], wb_data[4:0] qualify it.
REQ-013 dbg_addr  input  3; dbg_data  output  5  combinational read of register file.

Function
REQ-014 Register file SHALL be 8 x 5-bit.
REQ-015 FSM states SHALL be IDLE, ISSUE, EXEC.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 Handshake: instr_valid && instr_ready at a rising edge SHALL latch op/rs/rt/rd, load read_data_1=reg[rs], read_data_2=reg[rt], map ALUcontrol (00->0, 01->1, 10->2, 11->6), and move IDLE->ISSUE.
REQ-018 ISSUE SHALL hold operands and ALUcontrol stable one cycle, then go to EXEC unconditionally.
REQ-019 EXEC: at the edge ending EXEC, reg[rd] SHALL be written with ALUresult, wb_valid pulsed for the following cycle, FSM returns IDLE.
REQ-020 Throughput one instruction per 3 clocks; handshake-to-writeback latency 3 edges.
REQ-021 Arithmetic SHALL be 5-bit modulo (wrap); no carry/overflow flag.
REQ-022 Operands SHALL be read from the register file at handshake edge; rs/rt equal to rd of the previous instruction SHALL see its written value (writeback completes before next handshake).
REQ-023 Preload wr_en SHALL write reg[wr_addr] in any state.
REQ-024 Same-edge preload and writeback to same index: writeback SHALL win; different indices: both SHALL write.
REQ-025 Preload to rs/rt during ISSUE/EXEC SHALL NOT alter operands already latched.
REQ-026 instr_valid while not ready SHALL be ignored; no instruction lost or duplicated.
REQ-027 dbg_data SHALL reflect the register file combinationally, including writes at the last edge.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all registers 0, read_data_1/2=0, ALUcontrol=0, wb_valid=0, wb_rd=0, wb_data=0.
REQ-029 Reset mid-ISSUE/EXEC SHALL abort the instruction with no writeback.
REQ-030 First handshake SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-031 With ALU_ISSUE_R0_ZERO_EN defined, reg[0] SHALL read 0 always and writes to index 0 (preload or writeback) SHALL be discarded; wb_valid still pulses with wb_rd=0.
REQ-032 Without ALU_ISSUE_R0_ZERO_EN, reg[0] SHALL be an ordinary register.

Verification
REQ-033 Preload r1=9, r2=5; issue ADD rd=3 -> ALUcontrol=2, operands 9/5 in ISSUE, wb_valid with wb_rd=3, wb_data=14 three edges after handshake; dbg r3=14.
REQ-034 Preload r1=3, r2=5; SUB rd=4 -> wb_data=30 (wrap); AND -> 1; OR -> 7.
REQ-035 Hold instr_valid high with back-to-back instructions -> accepted every 3rd edge, instr_ready low in ISSUE/EXEC, dependent ADD r3=r3+r1 sees previous result.
REQ-036 Preload wr_addr=3 on same edge as writeback to r3 -> r3 = ALU result; preload to r2 same edge -> both written.
REQ-037 Assert rst_n low during EXEC -> no wb_valid, all registers 0, instr_ready=1 after release.
REQ-038 With ALU_ISSUE_R0_ZERO_EN: ADD rd=0 of 9+5 -> dbg r0=0; without: dbg r0=14.

Source files
------------

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue -- single-issue front end for an external 5-bit ALU.
//
// An 8 x DATA_W register file feeds a three-state issue FSM:
//   IDLE  : instr_ready high.
//           On handshake: latch rd, read the operands, map the opcode.
//   ISSUE : operands and ALUcontrol are held one cycle.
//           The external ALU samples them at the edge that leaves ISSUE.
//   EXEC  : the ALU presents its registered result.
//           The edge leaving EXEC writes reg[rd] and pulses wb_valid.
// The result is one instruction every three clocks.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid / instr_ready   instruction handshake
//   instr_op                    00 AND, 01 OR, 10 ADD, 11 SUB
//   instr_rs/rt/rd              source and destination register indices
//   wr_en/wr_addr/wr_data       preload write port, usable in any state
//   read_data_1/2, ALUcontrol   registered operands and opcode to the ALU
//   ALUresult                   registered result returned by the ALU
//   wb_valid/wb_rd/wb_data      one-cycle writeback pulse and its payload
//   dbg_addr/dbg_data           combinational register-file read
//
// Build option
//   ALU_ISSUE_R0_ZERO_EN : reg[0] always reads 0 and writes to it are
//                          dropped. wb_valid still pulses, with wb_rd = 0.
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [2:0]        instr_rs,
  input  logic [2:0]        instr_rt,
  input  logic [2:0]        instr_rd,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [3:0]        ALUcontrol,
  input  logic [DATA_W-1:0] ALUresult,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs [8];
  logic [2:0]        rd_p0;
  logic              accept;
  logic              wb_fire;
  logic              pre_we;
  logic              wb_we;
  logic [DATA_W-1:0] rs_val, rt_val;

  function automatic logic [3:0] alu_ctl_map(input logic [1:0] op);
    case (op)
      2'b00:   return 4'd0;
      2'b01:   return 4'd1;
      2'b10:   return 4'd2;
      default: return 4'd6;
    endcase
  endfunction

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    wb_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = EXEC;
      EXEC: begin
        wb_fire = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-file read ports; r0 is forced to zero when the option is built in
  always_comb begin
    rs_val   = regs[instr_rs];
    rt_val   = regs[instr_rt];
    dbg_data = regs[dbg_addr];
    if (R0_ZERO && instr_rs == 3'd0) rs_val = '0;
    if (R0_ZERO && instr_rt == 3'd0) rt_val = '0;
    if (R0_ZERO && dbg_addr == 3'd0) dbg_data = '0;
  end

  // A preload loses to a writeback on the same edge to the same index.
  // Writes to r0 are dropped when it is hard-wired to zero.
  always_comb begin
    pre_we = wr_en && !(R0_ZERO && wr_addr == 3'd0) &&
             !(wb_fire && wr_addr == rd_p0);
    wb_we  = wb_fire && !(R0_ZERO && rd_p0 == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_p0       <= '0;
      read_data_1 <= '0;
      read_data_2 <= '0;
      ALUcontrol  <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= 1'b0;

      // Handshake: operands are captured here and stay put until the next handshake
      if (accept) begin
        rd_p0       <= instr_rd;
        read_data_1 <= rs_val;
        read_data_2 <= rt_val;
        ALUcontrol  <= alu_ctl_map(instr_op);
      end

      if (pre_we) regs[wr_addr] <= wr_data;

      // End of EXEC: retire into the register file and announce it
      if (wb_fire) begin
        if (wb_we) regs[rd_p0] <= ALUresult;
        wb_valid <= 1'b1;
        wb_rd    <= rd_p0;
        wb_data  <= ALUresult;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [2:0] instr_rs, instr_rt, instr_rd;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [4:0] read_data_1, read_data_2;
  logic [3:0] ALUcontrol;
  logic [4:0] alu_q;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [4:0] wb_data;
  logic [2:0] dbg_addr;
  logic [4:0] dbg_data;

  alu_issue #(.DATA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .ALUcontrol(ALUcontrol),
    .ALUresult(alu_q),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: registers its result one clock after sampling operands
  always @(posedge clk) begin
    case (ALUcontrol)
      4'd0:    alu_q <= read_data_1 & read_data_2;
      4'd1:    alu_q <= read_data_1 | read_data_2;
      4'd2:    alu_q <= read_data_1 + read_data_2;
      4'd6:    alu_q <= read_data_1 - read_data_2;
      default: alu_q <= 5'd0;
    endcase
  end

  typedef struct {
    logic [2:0] rd;
    logic [4:0] data;
    int         edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;

  // Reference model state
  int   ref_regs [8];
  int   busy     = 0;   // edges left before the in-flight instruction retires
  int   cur_rd   = 0;
  int   cur_res  = 0;
  int   last_a   = 0;
  int   last_b   = 0;
  int   last_ctl = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int ref_rd(input int idx);
    if (R0Z && idx == 0) return 0;
    return ref_regs[idx];
  endfunction

  task automatic ref_wr(input int idx, input int val);
    if (!(R0Z && idx == 0)) ref_regs[idx] = val;
  endtask

  function automatic int op_eval(input int op, input int a, input int b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return (a + b) % 32;
      default: return (a - b + 32) % 32;
    endcase
  endfunction

  // One clock edge: the model reacts to the inputs present before the edge,
  // then the DUT's ready and operand registers are checked.
  task automatic tick();
    bit hs, wb;
    int a, b;
    hs = instr_valid && (busy == 0);
    wb = (busy == 1);
    a  = ref_rd(int'(instr_rs));
    b  = ref_rd(int'(instr_rt));
    @(posedge clk);
    edges++;
    if (wr_en) ref_wr(int'(wr_addr), int'(wr_data));
    if (wb) ref_wr(cur_rd, cur_res);
    if (busy > 0) busy--;
    else if (hs) begin
      exp_t e;
      cur_rd   = int'(instr_rd);
      cur_res  = op_eval(int'(instr_op), a, b);
      last_a   = a;
      last_b   = b;
      last_ctl = (instr_op == 2'd0) ? 0 : (instr_op == 2'd1) ? 1 : (instr_op == 2'd2) ? 2 : 6;
      e.rd      = instr_rd;
      e.data    = 5'(cur_res);
      e.edge_no = edges + 2;
      sb.push_back(e);
      busy = 2;
    end
    #1;
    chk("instr_ready", int'(instr_ready), (busy == 0) ? 1 : 0);
    if (busy > 0) begin
      chk("read_data_1", int'(read_data_1), last_a);
      chk("read_data_2", int'(read_data_2), last_b);
      chk("ALUcontrol", int'(ALUcontrol), last_ctl);
    end
  endtask

  task automatic dbg_chk(input string name, input int addr, input int req);
    dbg_addr = 3'(addr);
    #1;
    chk(name, int'(dbg_data), req);
  endtask

  task automatic preload(input int addr, input int val);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 5'(val);
    tick();
    wr_en = 1'b0;
  endtask

  // Issue one instruction and let it retire; optional preload on the writeback edge
  task automatic issue(input int op, input int rs, input int rt, input int rd,
                       input bit wb_pre, input int pa, input int pv);
    instr_valid = 1'b1;
    instr_op = 2'(op); instr_rs = 3'(rs); instr_rt = 3'(rt); instr_rd = 3'(rd);
    tick();
    instr_valid = 1'b0;
    tick();
    if (wb_pre) begin
      wr_en = 1'b1; wr_addr = 3'(pa); wr_data = 5'(pv);
    end
    tick();
    wr_en = 1'b0;
    #4;  // let the monitor see the writeback pulse
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_spurious actual=wb_valid(rd=%0d) required=no_writeback", wb_rd);
        end else begin
          e = sb.pop_front();
          chk("wb_rd", int'(wb_rd), int'(e.rd));
          chk("wb_data", int'(wb_data), int'(e.data));
          chk("wb_latency", edges, e.edge_no);
        end
      end else if (sb.size() > 0 && sb[0].edge_no <= edges) begin
        e = sb.pop_front();
        checks++; failures++;
        $display("FAIL wb_missing actual=no_writeback required=wb_rd=%0d wb_data=%0d", e.rd, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rs = '0; instr_rt = '0;
    instr_rd = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_rd1", int'(read_data_1), 0);
    chk("rst_ctl", int'(ALUcontrol), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    @(negedge clk) rst_n = 1'b1;

    // ADD 9+5 into r3
    preload(1, 9);
    preload(2, 5);
    issue(2, 1, 2, 3, 1'b0, 0, 0);
    dbg_chk("add_r3", 3, 14);

    // Wrap-around SUB, AND, OR
    preload(1, 3);
    preload(2, 5);
    issue(3, 1, 2, 4, 1'b0, 0, 0);
    dbg_chk("sub_wrap_r4", 4, 30);
    issue(0, 1, 2, 5, 1'b0, 0, 0);
    dbg_chk("and_r5", 5, 1);
    issue(1, 1, 2, 6, 1'b0, 0, 0);
    dbg_chk("or_r6", 6, 7);

    // Back-to-back dependent ADD r3 = r3 + r1
    preload(3, 0);
    preload(1, 3);
    instr_valid = 1'b1; instr_op = 2'd2; instr_rs = 3'd3; instr_rt = 3'd1; instr_rd = 3'd3;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) cnt++;
      tick();
    end
    instr_valid = 1'b0;
    #4;
    chk("b2b_accepts", cnt, 3);
    dbg_chk("b2b_r3", 3, 9);

    // Same-edge preload and writeback
    preload(1, 9);
    preload(2, 5);
    issue(2, 1, 2, 3, 1'b1, 3, 31);
    dbg_chk("wb_wins_r3", 3, 14);
    issue(2, 1, 2, 3, 1'b1, 2, 7);
    dbg_chk("both_r3", 3, 14);
    dbg_chk("both_r2", 2, 7);

    // Preload to a source register while in flight must not disturb operands
    instr_valid = 1'b1; instr_op = 2'd2; instr_rs = 3'd1; instr_rt = 3'd2; instr_rd = 3'd5;
    tick();
    instr_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'd20;
    tick();
    wr_en = 1'b0;
    tick();
    #4;
    dbg_chk("inflight_r5", 5, 16);

    // r0 as destination
    preload(1, 9);
    preload(2, 5);
    issue(2, 1, 2, 0, 1'b0, 0, 0);
    dbg_chk("r0_dest", 0, R0Z ? 0 : 14);

    // Reset in EXEC aborts the instruction
    instr_valid = 1'b1; instr_op = 2'd2; instr_rs = 3'd1; instr_rt = 3'd2; instr_rd = 3'd7;
    tick();
    instr_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    busy = 0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    chk("abort_wb_valid", int'(wb_valid), 0);
    chk("abort_ready", int'(instr_ready), 1);
    chk("abort_rd1", int'(read_data_1), 0);
    chk("abort_ctl", int'(ALUcontrol), 0);
    for (int i = 0; i < 8; i++) dbg_chk("abort_reg", i, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_ready", int'(instr_ready), 1);
    issue(1, 1, 2, 7, 1'b0, 0, 0);
    dbg_chk("post_rst_r7", 7, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr_op = 2'($urandom); instr_rs = 3'($urandom); instr_rt = 3'($urandom);
      instr_rd = 3'($urandom);
      wr_en = ($urandom_range(0, 9) < 3);
      wr_addr = 3'($urandom); wr_data = 5'($urandom);
      tick();
      begin
        int a;
        a = int'($urandom_range(0, 7));
        dbg_chk("rand_dbg", a, ref_rd(a));
      end
    end
    instr_valid = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 10 && busy != 0; i++) tick();
    #5;
    chk("drain_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
